// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with per-requester credits and a
// grant lock that holds an offered grant stable until the consumer accepts it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   req         per-requester request (level)
//   cfg_load    one-cycle strobe: load cfg_weight and reload all credits
//   cfg_weight  weight of requester i in bits [i*CW +: CW] (0 behaves as 1)
//   grt         one-hot grant, or zero
//   grt_valid   |grt
//   grt_id      binary index of grt, 0 when no grant
//   grt_ready   consumer accepts the grant (handshake = grt_valid & grt_ready)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | grant chosen fresh each cycle by weighted round-robin
// LOCK    | last grant was not accepted; keep offering r_lk while requested
module wrr_arbiter #(
   parameter int WIDTH = 8,
   parameter int CW    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           req,
   input  logic                       cfg_load,
   input  logic [WIDTH*CW-1:0]        cfg_weight,
   output logic [WIDTH-1:0]           grt,
   output logic                       grt_valid,
   output logic [$clog2(WIDTH)-1:0]   grt_id,
   input  logic                       grt_ready
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [WIDTH-1:0] r_mrg;
   logic [WIDTH-1:0] r_lk;
   logic [0:0]       r_state;
   logic [CW-1:0]    r_weight [WIDTH];
   logic [CW-1:0]    r_credit [WIDTH];

   logic [CW-1:0]    w_eff     [WIDTH];
   logic [CW-1:0]    w_new_eff [WIDTH];
   logic [WIDTH-1:0] w_elig;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_sel;
   logic             w_refill;
   logic             w_hold;
   logic             w_hs;
   logic             w_found;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_eff[i]     = (r_weight[i] == '0) ? CW'(1) : r_weight[i];
         w_new_eff[i] = (cfg_weight[i*CW +: CW] == '0) ? CW'(1) : cfg_weight[i*CW +: CW];
         w_elig[i]    = req[i] & (r_credit[i] != '0);
      end
   end

   // Once every requester has spent its credits, arbitrate over raw req;
   // the handshake of such a round reloads all credits.
   assign w_refill = (w_elig == '0);
   assign w_base   = w_refill ? req : w_elig;

   // Round-robin pick: scan upward from the position after the most recent
   // grantee. r_mrg is one-hot, so exactly one outer iteration is active;
   // all indices are loop constants.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int m = 0; m < WIDTH; m++) begin
         if (r_mrg[m]) begin
            for (int k = 1; k <= WIDTH; k++) begin
               if (!w_found && w_base[(m + k) % WIDTH]) begin
                  w_sel[(m + k) % WIDTH] = 1'b1;
                  w_found                = 1'b1;
               end
            end
         end
      end
   end

   // A withdrawn locked requester falls straight back to the fresh pick.
   assign w_hold    = (r_state == ST_LOCK) && ((req & r_lk) != '0);
   assign grt       = w_hold ? r_lk : w_sel;
   assign grt_valid = |grt;
   assign w_hs      = grt_valid & grt_ready;

   always_comb begin
      grt_id = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (grt[i]) grt_id = IW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mrg   <= {1'b1, {(WIDTH-1){1'b0}}};
         r_lk    <= '0;
         r_state <= ST_IDLE;
         for (int i = 0; i < WIDTH; i++) begin
            r_weight[i] <= CW'(1);
            r_credit[i] <= CW'(1);
         end
      end else begin
         if (w_hs) begin
            r_mrg   <= grt;
            r_state <= ST_IDLE;
            r_lk    <= '0;
         end else if (grt_valid) begin
            r_state <= ST_LOCK;
            r_lk    <= grt;
         end else begin
            r_state <= ST_IDLE;
            r_lk    <= '0;
         end

         if (cfg_load) begin
            for (int i = 0; i < WIDTH; i++) begin
               r_weight[i] <= cfg_weight[i*CW +: CW];
               r_credit[i] <= w_new_eff[i];
            end
         end else if (w_hs) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (w_refill) begin
                  r_credit[i] <= grt[i] ? (w_eff[i] - CW'(1)) : w_eff[i];
               end else if (grt[i] && (r_credit[i] != '0)) begin
                  // A grant locked during a refill round can be accepted in a
                  // later non-refill round with zero credit; never wrap.
                  r_credit[i] <= r_credit[i] - CW'(1);
               end
            end
         end
      end
   end

endmodule
